// File: rtl/riscv_pc_unit.sv
// Program counter and next-PC unit: boot/run/trap sequencing, redirects, misalignment traps.
// Latency: next PC, flush, misalign and epc are registered (one cycle after the decision inputs).
// Backpressure: stall_i holds the PC and blocks every redirect except a trap.
module riscv_pc_unit #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  input  logic         branch_i,
  input  logic         jal_i,
  input  logic         jalr_i,
  input  logic         alu_flag_i,
  input  logic [N-1:0] imm_i,
  input  logic [N-1:0] rs1_i,
  input  logic         trap_i,
  input  logic         mret_i,
  input  logic [N-1:0] mtvec_i,
  input  logic [N-1:0] mepc_i,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic         valid_o,
  output logic         flush_o,
  output logic         misalign_o,
  output logic [N-1:0] epc_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [N-1:0] MASK_W = {{(N-2){1'b0}}, 2'b11};
  localparam logic [N-1:0] MASK_H = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] FOUR   = {{(N-3){1'b0}}, 3'b100};

  state_t         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [N-1:0]   epc_q, epc_d;
  logic           valid_q, valid_d;
  logic           flush_q, flush_d;
  logic           mis_q, mis_d;

  logic [N-1:0]   trap_pc;
  logic [N-1:0]   ret_pc;
  logic [N-1:0]   jalr_sum;
  logic [N-1:0]   tgt;
  logic           ctl_taken;

  // Candidate targets: trap vector, mret return, and the jump/branch target.
  always_comb begin
    trap_pc   = mtvec_i & ~MASK_W;
    ret_pc    = mepc_i & ~MASK_W;
    jalr_sum  = rs1_i + imm_i;
    tgt       = jalr_i ? (jalr_sum & ~MASK_H) : (pc_q + imm_i);
    ctl_taken = jalr_i | jal_i | (branch_i & alu_flag_i);
  end

  // Next-state selection; pulses default low so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      TRAP: state_d = RUN;
      RUN: begin
        if (trap_i) begin
          pc_d    = trap_pc;
          epc_d   = pc_q;
          flush_d = 1'b1;
          state_d = TRAP;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (mret_i) begin
          pc_d    = ret_pc;
          flush_d = 1'b1;
        end else if (ctl_taken) begin
          flush_d = 1'b1;
          if (tgt[1]) begin
            // Target not word aligned: take the misalignment trap instead.
            pc_d    = trap_pc;
            epc_d   = pc_q;
            mis_d   = 1'b1;
            state_d = TRAP;
          end else begin
            pc_d = tgt;
          end
        end else begin
          pc_d = pc_q + FOUR;
        end
      end
      default: state_d = BOOT;
    endcase
    valid_d = (state_d == RUN);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + FOUR;
  assign valid_o    = valid_q;
  assign flush_o    = flush_q;
  assign misalign_o = mis_q;
  assign epc_o      = epc_q;

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Testbench for riscv_pc_unit: directed scenarios plus randomized run against a reference model.
// Each tick advances the model from the architectural rules, then outputs are compared #1 after the edge.
// Stimulus is applied with blocking assignments between edges.
module tb_riscv_pc_unit;
  localparam logic [31:0] RST = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n, stall, branch, jal, jalr, flag, trap, mret;
  logic [31:0] imm, rs1, mtvec, mepc;
  logic [31:0] pc_o, pc4_o, epc_o;
  logic valid_o, flush_o, mis_o;

  int compared = 0;
  int mismatched = 0;

  // reference model state: mode 0=boot 1=run 2=trap
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_flush, m_mis;

  always #5 clk = ~clk;

  riscv_pc_unit #(.N(32), .RESET_PC(RST)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_i(branch), .jal_i(jal),
    .jalr_i(jalr), .alu_flag_i(flag), .imm_i(imm), .rs1_i(rs1), .trap_i(trap),
    .mret_i(mret), .mtvec_i(mtvec), .mepc_i(mepc), .pc_o(pc_o), .pc_plus4_o(pc4_o),
    .valid_o(valid_o), .flush_o(flush_o), .misalign_o(mis_o), .epc_o(epc_o)
  );

  wire [98:0] act = {pc_o, pc4_o, valid_o, flush_o, mis_o, epc_o};

  function automatic logic [98:0] expv();
    return {m_pc, m_pc + 32'd4, (m_mode == 1), m_flush, m_mis, m_epc};
  endfunction

  task automatic idle();
    stall = 0; branch = 0; jal = 0; jalr = 0; flag = 0; trap = 0; mret = 0;
    imm = 0; rs1 = 0;
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] t;
    logic        take;
    int          nmode;
    logic [31:0] npc, nepc;
    logic        nfl, nmi;
    nmode = m_mode; npc = m_pc; nepc = m_epc; nfl = 0; nmi = 0;
    if (!rst_n) begin
      nmode = 0; npc = RST; nepc = 0;
    end else if (m_mode != 1) begin
      nmode = 1;
    end else if (trap) begin
      npc = {mtvec[31:2], 2'b00}; nepc = m_pc; nfl = 1; nmode = 2;
    end else if (stall) begin
      npc = m_pc;
    end else if (mret) begin
      npc = {mepc[31:2], 2'b00}; nfl = 1;
    end else begin
      take = 1;
      if (jalr)               t = (rs1 + imm) & 32'hFFFF_FFFE;
      else if (jal)           t = m_pc + imm;
      else if (branch && flag) t = m_pc + imm;
      else                    take = 0;
      if (!take) npc = m_pc + 32'd4;
      else begin
        nfl = 1;
        if (t[1]) begin
          npc = {mtvec[31:2], 2'b00}; nepc = m_pc; nmi = 1; nmode = 2;
        end else npc = t;
      end
    end
    @(posedge clk);
    #1;
    m_mode = nmode; m_pc = npc; m_epc = nepc; m_flush = nfl; m_mis = nmi;
  endtask

  task automatic test_reset();
    idle(); mtvec = 32'h0000_0803; mepc = 32'h0000_0400;
    rst_n = 0; tick(); tick();
    compared++;
    if (act !== {RST, RST + 32'd4, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      mismatched++; $display("FAIL reset_state act=%h exp=%h", act, {RST, RST + 32'd4, 3'b000, 32'd0});
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (act !== expv() || pc_o !== RST + 32'(4 * i) || valid_o !== 1'b1) begin
        mismatched++; $display("FAIL boot_seq[%0d] act=%h exp=%h", i, act, expv());
      end
    end
  endtask

  task automatic test_branch();
    idle(); jal = 1; imm = 32'h200 - m_pc; tick(); idle();
    compared++;
    if (pc_o !== 32'h200 || flush_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL jal_to_200 act=%h exp=%h", act, expv());
    end
    branch = 1; flag = 1; imm = -32'sd8; tick(); idle();
    compared++;
    if (pc_o !== 32'h1F8 || flush_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL branch_taken act=%h exp=%h", act, expv());
    end
    tick();
    compared++;
    if (pc_o !== 32'h1FC || flush_o !== 1'b0 || act !== expv()) begin
      mismatched++; $display("FAIL flush_one_cycle act=%h exp=%h", act, expv());
    end
    jal = 1; imm = 32'h4; tick();
    branch = 1; flag = 0; jal = 0; imm = -32'sd8; tick(); idle();
    compared++;
    if (pc_o !== 32'h204 || flush_o !== 1'b0 || act !== expv()) begin
      mismatched++; $display("FAIL branch_not_taken act=%h exp=%h", act, expv());
    end
  endtask

  task automatic test_jalr();
    logic [31:0] old;
    old = m_pc;
    jalr = 1; rs1 = 32'h1001; imm = 32'd2; tick(); idle();
    compared++;
    if (mis_o !== 1'b1 || epc_o !== old || pc_o !== 32'h800 || valid_o !== 1'b0 || act !== expv()) begin
      mismatched++; $display("FAIL jalr_misalign act=%h exp=%h", act, expv());
    end
    tick();
    compared++;
    if (pc_o !== 32'h800 || valid_o !== 1'b1 || mis_o !== 1'b0 || act !== expv()) begin
      mismatched++; $display("FAIL trap_bubble_exit act=%h exp=%h", act, expv());
    end
    jalr = 1; rs1 = 32'h3001; imm = 32'd0; tick(); idle();
    compared++;
    if (pc_o !== 32'h3000 || mis_o !== 1'b0 || flush_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL jalr_bit0_clear act=%h exp=%h", act, expv());
    end
    mret = 1; tick(); idle();
    compared++;
    if (pc_o !== 32'h400 || flush_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL mret act=%h exp=%h", act, expv());
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = m_pc;
    stall = 1; jal = 1; imm = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (pc_o !== held || flush_o !== 1'b0 || act !== expv()) begin
        mismatched++; $display("FAIL stall_hold[%0d] act=%h exp=%h", i, act, expv());
      end
    end
    trap = 1; tick(); idle();
    compared++;
    if (pc_o !== 32'h800 || epc_o !== held || flush_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL stall_trap act=%h exp=%h", act, expv());
    end
    trap = 1; tick(); idle();
    compared++;
    if (pc_o !== 32'h800 || epc_o !== held || valid_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL trap_in_trap_dropped act=%h exp=%h", act, expv());
    end
  endtask

  task automatic test_wrap();
    jal = 1; imm = 32'hFFFF_FFFC - m_pc; tick(); idle();
    compared++;
    if (pc_o !== 32'hFFFF_FFFC || pc4_o !== 32'h0 || act !== expv()) begin
      mismatched++; $display("FAIL wrap_pc4 act=%h exp=%h", act, expv());
    end
    tick();
    compared++;
    if (pc_o !== 32'h0 || flush_o !== 1'b0 || act !== expv()) begin
      mismatched++; $display("FAIL wrap_seq act=%h exp=%h", act, expv());
    end
  endtask

  task automatic test_reset_in_trap();
    trap = 1; tick(); idle();
    rst_n = 0; tick();
    compared++;
    if (pc_o !== RST || valid_o !== 1'b0 || epc_o !== 32'h0 || act !== expv()) begin
      mismatched++; $display("FAIL reset_in_trap act=%h exp=%h", act, expv());
    end
    rst_n = 1; tick();
    compared++;
    if (pc_o !== RST || valid_o !== 1'b1 || act !== expv()) begin
      mismatched++; $display("FAIL reboot act=%h exp=%h", act, expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      stall  = ($urandom_range(0, 5) == 0);
      trap   = ($urandom_range(0, 11) == 0);
      mret   = ($urandom_range(0, 11) == 0);
      jalr   = ($urandom_range(0, 7) == 0);
      jal    = ($urandom_range(0, 7) == 0);
      branch = ($urandom_range(0, 3) == 0);
      flag   = $urandom_range(0, 1);
      imm    = jalr ? $urandom_range(0, 255) - 128 : (($urandom_range(0, 4095) - 2048) & 32'hFFFF_FFFE);
      rs1    = $urandom;
      mtvec  = $urandom;
      mepc   = $urandom;
      tick();
      compared++;
      if (act !== expv()) begin
        mismatched++; $display("FAIL random[%0d] act=%h exp=%h", i, act, expv());
      end
    end
  endtask

  initial begin
    m_mode = 0; m_pc = RST; m_epc = 0; m_flush = 0; m_mis = 0;
    rst_n = 0; mtvec = 0; mepc = 0;
    idle();
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_wrap();
    test_reset_in_trap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
